// File: rtl/ipif_mst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ipif_mst_pkg
//  Description : Shared types and helpers for the IPIF master responder.
//  Revision    : 1.0
// ============================================================================
package ipif_mst_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int c_cnt_w = 4;

   // Byte lanes follow IPIF big-endian numbering: be[0] covers bits [0:7].
   function automatic logic [0:31] be_merge(input logic [0:31] old_word,
                                            input logic [0:31] new_word,
                                            input logic [0:3]  be);
      logic [0:31] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ipif_mst_mem.sv
`default_nettype none
// ============================================================================
//  Module      : ipif_mst_mem
//  Description : Single-port 32-bit RAM, byte-enable write, registered read.
//  Revision    : 1.0
// ============================================================================
module ipif_mst_mem
   import ipif_mst_pkg::*;
#(
   parameter int MEM_AW = 10
) (
   input  logic              clk,
   input  logic [MEM_AW-1:0] i_addr,
   input  logic              i_rd_en,
   input  logic              i_wr_en,
   input  logic [0:3]        i_be,
   input  logic [0:31]       i_wdata,
   output logic [0:31]       o_rdata
);

   logic [0:31] r_mem [0:(2**MEM_AW)-1];
   logic [0:31] r_rdata;

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_addr] <= be_merge(r_mem[i_addr], i_wdata, i_be);
      end
      if (i_rd_en) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ipif_mst_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ipif_mst_responder
//  Description : IPIF master-command responder backed by a local RAM.
//  Revision    : 1.0
// ============================================================================
module ipif_mst_responder
   import ipif_mst_pkg::*;
#(
   parameter int         MEM_AW   = 10,
   parameter int         CMD_LAT  = 2,
   parameter int         DATA_LAT = 1,
   parameter logic [0:3] ERR_TAG  = 4'hF,
   parameter bit         ERR_EN   = 1'b1
) (
   input  logic        Bus2IP_Clk,
   input  logic        Bus2IP_Reset,
   input  logic        IP2Bus_MstRd_Req,
   input  logic        IP2Bus_MstWr_Req,
   input  logic [0:31] IP2Bus_Mst_Addr,
   input  logic [0:3]  IP2Bus_Mst_BE,
   input  logic        IP2Bus_Mst_Lock,
   input  logic        IP2Bus_Mst_Reset,
   input  logic [0:31] IP2Bus_MstWr_d,
   output logic        Bus2IP_Mst_CmdAck,
   output logic        Bus2IP_Mst_Cmplt,
   output logic        Bus2IP_Mst_Error,
   output logic        Bus2IP_Mst_Rearbitrate,
   output logic        Bus2IP_Mst_Cmd_Timeout,
   output logic [0:31] Bus2IP_MstRd_d,
   output logic        Bus2IP_MstRd_src_rdy_n,
   output logic        Bus2IP_MstWr_dst_rdy_n
);

   localparam logic [c_cnt_w-1:0] c_cmd_load  = c_cnt_w'(CMD_LAT - 1);
   localparam logic [c_cnt_w-1:0] c_data_load = c_cnt_w'(DATA_LAT - 1);
   localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

   state_t              r_state, w_state_nxt;
   logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
   logic [MEM_AW-1:0]   r_idx;
   logic [0:3]          r_be;
   logic                r_is_rd, r_err;
   logic                r_cmd_ack, r_cmplt, r_error, r_src_rdy_n, r_dst_rdy_n;
   logic                w_cmd_ack, w_cmplt, w_error, w_src_rdy_n, w_dst_rdy_n;
   logic                w_latch, w_mem_rd_en, w_mem_wr_en, w_req_held;
   logic [MEM_AW-1:0]   w_idx;
   logic                w_err;
   logic [0:31]         w_mem_rdata;
   logic                w_unused;

   assign w_idx      = IP2Bus_Mst_Addr[30-MEM_AW:29];
   assign w_err      = ERR_EN && (IP2Bus_Mst_Addr[0:3] == ERR_TAG);
   assign w_req_held = r_is_rd ? IP2Bus_MstRd_Req : IP2Bus_MstWr_Req;
   assign w_unused   = ^{IP2Bus_Mst_Lock, IP2Bus_Mst_Addr};

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cmd_ack   = 1'b0;
      w_cmplt     = 1'b0;
      w_error     = 1'b0;
      w_src_rdy_n = 1'b1;
      w_dst_rdy_n = 1'b1;
      w_mem_rd_en = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         IDLE: begin
            if (IP2Bus_MstRd_Req || IP2Bus_MstWr_Req) begin
               w_latch     = 1'b1;
               w_cnt_nxt   = c_cmd_load;
               w_state_nxt = CMD;
            end
         end
         CMD: begin
            if (!w_req_held) begin
               w_state_nxt = IDLE;
            end else if (r_cnt == '0) begin
               w_cmd_ack   = 1'b1;
               w_cnt_nxt   = c_data_load;
               w_state_nxt = DATA;
            end else begin
               w_cnt_nxt = r_cnt - c_one;
            end
         end
         DATA: begin
            if (r_cnt == '0) begin
               if (r_err) begin
                  w_cmplt     = 1'b1;
                  w_error     = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DONE;
                  if (r_is_rd) begin
                     w_src_rdy_n = 1'b0;
                     w_mem_rd_en = 1'b1;
                  end else begin
                     w_dst_rdy_n = 1'b0;
                  end
               end
            end else begin
               w_cnt_nxt = r_cnt - c_one;
            end
         end
         DONE: begin
            w_cmplt     = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      // Initiator abort overrides everything decided above.
      if (IP2Bus_Mst_Reset) begin
         w_state_nxt = IDLE;
         w_cmd_ack   = 1'b0;
         w_cmplt     = 1'b0;
         w_error     = 1'b0;
         w_src_rdy_n = 1'b1;
         w_dst_rdy_n = 1'b1;
         w_mem_rd_en = 1'b0;
         w_latch     = 1'b0;
      end
   end

   always_ff @(posedge Bus2IP_Clk) begin
      if (Bus2IP_Reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_be        <= '0;
         r_is_rd     <= 1'b0;
         r_err       <= 1'b0;
         r_cmd_ack   <= 1'b0;
         r_cmplt     <= 1'b0;
         r_error     <= 1'b0;
         r_src_rdy_n <= 1'b1;
         r_dst_rdy_n <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_cmd_ack   <= w_cmd_ack;
         r_cmplt     <= w_cmplt;
         r_error     <= w_error;
         r_src_rdy_n <= w_src_rdy_n;
         r_dst_rdy_n <= w_dst_rdy_n;
         if (w_latch) begin
            r_idx   <= w_idx;
            r_be    <= IP2Bus_Mst_BE;
            r_is_rd <= IP2Bus_MstRd_Req;
            r_err   <= w_err;
         end
      end
   end

   // Write data is taken at the end of the dst_rdy_n beat, so an abort in that cycle still commits.
   assign w_mem_wr_en = (r_state == DONE) && !r_is_rd && !Bus2IP_Reset;

   ipif_mst_mem #(
      .MEM_AW (MEM_AW)
   ) u_mem (
      .clk     (Bus2IP_Clk),
      .i_addr  (r_idx),
      .i_rd_en (w_mem_rd_en),
      .i_wr_en (w_mem_wr_en),
      .i_be    (r_be),
      .i_wdata (IP2Bus_MstWr_d),
      .o_rdata (w_mem_rdata)
   );

   assign Bus2IP_Mst_CmdAck      = r_cmd_ack;
   assign Bus2IP_Mst_Cmplt       = r_cmplt;
   assign Bus2IP_Mst_Error       = r_error;
   assign Bus2IP_Mst_Rearbitrate = 1'b0;
   assign Bus2IP_Mst_Cmd_Timeout = 1'b0;
   assign Bus2IP_MstRd_src_rdy_n = r_src_rdy_n;
   assign Bus2IP_MstWr_dst_rdy_n = r_dst_rdy_n;
   assign Bus2IP_MstRd_d         = r_src_rdy_n ? '0 : w_mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ipif_mst_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ipif_mst_responder
//  Description : Directed, table-driven bench for ipif_mst_responder.
//  Revision    : 1.0
// ============================================================================
module tb_ipif_mst_responder;

   localparam int CMD_LAT  = 2;
   localparam int DATA_LAT = 1;
   localparam int ACK_C    = CMD_LAT;
   localparam int BEAT_C   = CMD_LAT + DATA_LAT;
   localparam int N_CYC    = BEAT_C + 3;
   localparam logic [38:0] c_idle = {2'b00, 3'b000, 2'b11, 32'h0};

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_req, wr_req, lock, mrst;
   logic [0:31] addr, wd;
   logic [0:3]  be;
   logic        cmd_ack, cmplt, error, rearb, tmo, src_rdy_n, dst_rdy_n;
   logic [0:31] rd_d;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      bit          err;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs [13];

   always #5 clk = ~clk;

   ipif_mst_responder #(
      .MEM_AW   (10),
      .CMD_LAT  (CMD_LAT),
      .DATA_LAT (DATA_LAT),
      .ERR_TAG  (4'hF),
      .ERR_EN   (1'b1)
   ) dut (
      .Bus2IP_Clk             (clk),
      .Bus2IP_Reset           (rst),
      .IP2Bus_MstRd_Req       (rd_req),
      .IP2Bus_MstWr_Req       (wr_req),
      .IP2Bus_Mst_Addr        (addr),
      .IP2Bus_Mst_BE          (be),
      .IP2Bus_Mst_Lock        (lock),
      .IP2Bus_Mst_Reset       (mrst),
      .IP2Bus_MstWr_d         (wd),
      .Bus2IP_Mst_CmdAck      (cmd_ack),
      .Bus2IP_Mst_Cmplt       (cmplt),
      .Bus2IP_Mst_Error       (error),
      .Bus2IP_Mst_Rearbitrate (rearb),
      .Bus2IP_Mst_Cmd_Timeout (tmo),
      .Bus2IP_MstRd_d         (rd_d),
      .Bus2IP_MstRd_src_rdy_n (src_rdy_n),
      .Bus2IP_MstWr_dst_rdy_n (dst_rdy_n)
   );

   task automatic check(input string name, input int c, input logic [38:0] exp);
      logic [38:0] act;
      act = {rearb, tmo, cmd_ack, cmplt, error, src_rdy_n, dst_rdy_n, rd_d};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
      end
   endtask

   // Called just after a clock edge; cycle c is the cycle following edge T0+c.
   // cut >= 0 drops the request (or pulses Mst_Reset) after sampling cycle cut.
   task automatic run_xfer(input vec_t v, input int cut, input bit use_mrst);
      logic [38:0] exp;
      bit          beat;
      rd_req = v.rd;
      wr_req = v.wr;
      addr   = v.addr;
      be     = v.be;
      wd     = v.wdata;
      for (int c = 0; c < N_CYC; c++) begin
         @(posedge clk);
         #1;
         beat = !v.err && (c == BEAT_C);
         exp  = {2'b00,
                 (c == ACK_C),
                 (v.err ? (c == BEAT_C) : (c == BEAT_C + 1)),
                 (v.err && (c == BEAT_C)),
                 !(beat && v.rd),
                 !(beat && !v.rd),
                 ((beat && v.rd) ? v.rdata : 32'h0)};
         if (cut >= 0 && c > cut) exp = c_idle;
         check(v.name, c, exp);
         if (c == ACK_C) begin
            rd_req = 1'b0;
            wr_req = 1'b0;
         end
         if (cut >= 0 && c == cut) begin
            if (use_mrst) begin
               mrst = 1'b1;
            end else begin
               rd_req = 1'b0;
               wr_req = 1'b0;
            end
         end
         if (use_mrst && c == cut + 1) mrst = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t t;
      vecs[0]  = '{"wr_full",      1, 0, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0};
      vecs[1]  = '{"rd_full",      1'b1, 0, 32'h0000_0010, 4'b1111, 32'h0, 0, 32'hDEAD_BEEF};
      vecs[0].rd = 1'b0; vecs[0].wr = 1'b1;
      vecs[2]  = '{"wr_be0101",    0, 1, 32'h0000_0010, 4'b0101, 32'h1122_3344, 0, 32'h0};
      vecs[3]  = '{"rd_merge",     1, 0, 32'h0000_0010, 4'b1111, 32'h0, 0, 32'hDE22_BE44};
      vecs[4]  = '{"wr_word0",     0, 1, 32'h0000_0000, 4'b1111, 32'hA5A5_5A5A, 0, 32'h0};
      vecs[5]  = '{"rd_err",       1, 0, 32'hF000_0000, 4'b1111, 32'h0, 1, 32'h0};
      vecs[6]  = '{"wr_err",       0, 1, 32'hF000_0000, 4'b1111, 32'hFFFF_FFFF, 1, 32'h0};
      vecs[7]  = '{"rd_after_err", 1, 0, 32'h0000_0000, 4'b1111, 32'h0, 0, 32'hA5A5_5A5A};
      vecs[8]  = '{"wr_wrap",      0, 1, 32'h0000_1004, 4'b1111, 32'hCAFE_F00D, 0, 32'h0};
      vecs[9]  = '{"rd_wrap",      1, 0, 32'h0000_0004, 4'b1111, 32'h0, 0, 32'hCAFE_F00D};
      vecs[10] = '{"wr_be0000",    0, 1, 32'h0000_0010, 4'b0000, 32'h0000_0000, 0, 32'h0};
      vecs[11] = '{"rd_wr_both",   1, 1, 32'h0000_0010, 4'b1111, 32'h0000_0000, 0, 32'hDE22_BE44};
      vecs[12] = '{"rd_lowbits",   1, 0, 32'h0000_0013, 4'b0000, 32'h0, 0, 32'hDE22_BE44};

      rst    = 1'b1;
      rd_req = 1'b0;
      wr_req = 1'b0;
      lock   = 1'b0;
      mrst   = 1'b0;
      addr   = '0;
      be     = '0;
      wd     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset", 0, c_idle);
      rst  = 1'b0;
      lock = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 13; i++) begin
         run_xfer(vecs[i], -1, 1'b0);
      end

      t = '{"req_drop", 1, 0, 32'h0000_0010, 4'b1111, 32'h0, 0, 32'hDE22_BE44};
      run_xfer(t, 0, 1'b0);
      t.name = "rd_after_drop";
      run_xfer(t, -1, 1'b0);

      t = '{"mrst_data", 0, 1, 32'h0000_0010, 4'b1111, 32'h0BAD_F00D, 0, 32'h0};
      run_xfer(t, ACK_C, 1'b1);
      t = '{"rd_after_mrst", 1, 0, 32'h0000_0010, 4'b1111, 32'h0, 0, 32'hDE22_BE44};
      run_xfer(t, -1, 1'b0);

      t = '{"mrst_beat", 0, 1, 32'h0000_0008, 4'b1111, 32'h1234_5678, 0, 32'h0};
      run_xfer(t, BEAT_C, 1'b1);
      t = '{"rd_after_beat", 1, 0, 32'h0000_0008, 4'b1111, 32'h0, 0, 32'h1234_5678};
      run_xfer(t, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ipif_mst_responder.md
# ipif_mst_responder

Synthesizable responder for the IPIF master command interface that the LLDMA engine uses as initiator. It sits on the bus side of that interface in simulation and standalone bring-up. It accepts single-beat read and write commands from the IP2Bus_Mst* signals and services them from an internal word-addressed memory. It returns CmdAck, data-phase handshakes, Cmplt and Error with programmable latency and an error-injection window.

## Interface
Parameters:
- MEM_AW, 10, log2 of memory depth in 32-bit words
- CMD_LAT, 2, cycles from request sample to CmdAck (1..15)
- DATA_LAT, 1, cycles from CmdAck to data beat (1..15)
- ERR_TAG, 4'hF, Mst_Addr[0:3] value that selects the error window
- ERR_EN, 1, enables error injection

Ports:
- Bus2IP_Clk  in  1  sole clock, all logic on rising edge
- Bus2IP_Reset  in  1  synchronous, active-high reset
- IP2Bus_MstRd_Req  in  1  read command request
- IP2Bus_MstWr_Req  in  1  write command request
- IP2Bus_Mst_Addr  in  [0:31]  byte address, bit 0 MSB
- IP2Bus_Mst_BE  in  [0:3]  byte enables, BE[0] = lane [0:7]
- IP2Bus_Mst_Lock  in  1  ignored
- IP2Bus_Mst_Reset  in  1  initiator-side abort
- IP2Bus_MstWr_d  in  [0:31]  write data
- Bus2IP_Mst_CmdAck  out  1  command accepted, 1-cycle pulse
- Bus2IP_Mst_Cmplt  out  1  transfer complete, 1-cycle pulse
- Bus2IP_Mst_Error  out  1  error, valid with Cmplt
- Bus2IP_Mst_Rearbitrate  out  1  constant 0
- Bus2IP_Mst_Cmd_Timeout  out  1  constant 0
- Bus2IP_MstRd_d  out  [0:31]  read data, zero when src_rdy_n=1
- Bus2IP_MstRd_src_rdy_n  out  1  read beat valid, active low
- Bus2IP_MstWr_dst_rdy_n  out  1  write beat accepted, active low

## Operation
- FSM states and transitions:
  - IDLE: on sampled Rd or Wr req, latch addr, BE, dir and err, load the latency counter with CMD_LAT-1, and go to CMD.
  - CMD: counter at 0 → assert CmdAck for 1 cycle, load DATA_LAT-1, go to DATA. If the request drops before ack, return to IDLE with no ack.
  - DATA: counter at 0 → perform the beat and go to DONE. Error transfers skip the beat and assert Cmplt+Error in this cycle instead, then return to IDLE.
  - DONE: Cmplt for 1 cycle, Error=0, then go to IDLE.
- Rd and Wr both asserted in IDLE: read wins; write is ignored until re-requested.
- Word index = Mst_Addr[30-MEM_AW:29]. Addr[30:31] and higher unused bits are ignored, so addresses wrap modulo the memory size.
- Error transfer: ERR_EN=1 and Mst_Addr[0:3]==ERR_TAG. On error, memory is untouched and no src_rdy_n/dst_rdy_n pulse is issued.
- Read beat: src_rdy_n=0 for 1 cycle; MstRd_d = mem[idx] (all 32 bits, BE ignored).
- Write beat: dst_rdy_n=0 for 1 cycle. At that edge, IP2Bus_MstWr_d is merged into mem[idx] per BE. BE=0000 completes normally with no change.
- Lock is ignored. Rearbitrate and Cmd_Timeout are never asserted.
- IP2Bus_Mst_Reset=1 in any state: next state is IDLE and all pulses are deasserted. A write beat in the same cycle still commits; no Cmplt follows.

## Timing
- Reset values:
  - CmdAck = 0, Cmplt = 0, Error = 0
  - src_rdy_n = 1, dst_rdy_n = 1
  - MstRd_d = 0
  - FSM in IDLE
- Memory contents are not reset.
- Request sampled at edge T0. CmdAck is high in cycle T0+CMD_LAT. The beat is in cycle T0+CMD_LAT+DATA_LAT. Cmplt is in the following cycle.
- Error transfer: Cmplt+Error occur in cycle T0+CMD_LAT+DATA_LAT.
- At most one outstanding command. Requests are not sampled outside IDLE; the next command is sampled no earlier than the cycle after Cmplt.
- Read data is registered from memory: the read is issued when the counter hits 0 in DATA, so data is valid exactly with src_rdy_n low.
- Back-to-back writes then a read of the same word return the latest value (no read-before-write hazard).
- Bus2IP_Reset mid-transfer: outputs return to reset values at the next edge; no pending Cmplt.

## Structure
- Shared package ipif_mst_pkg:
  - state enum (IDLE, CMD, DATA, DONE)
  - 4-bit latency counter width
  - BE lane-merge function
- One sub-module, ipif_mst_mem: a single-port MEM_AW×32 RAM with byte-enable write and registered read.
- FSM, counter and address decode live in the top module.

## Test plan
- CMD_LAT=2, DATA_LAT=1, write 0xDEADBEEF to 0x0000_0010 with BE=1111:
  - CmdAck at T0+2, dst_rdy_n low at T0+3, Cmplt at T0+4, Error=0.
- Read 0x0000_0010 after that write:
  - src_rdy_n low with MstRd_d=0xDEADBEEF; all other cycles MstRd_d=0.
- Write 0x11223344 with BE=0101 over 0xDEADBEEF, then read:
  - read returns 0xDE22BE44.
- Read of 0xF000_0000 with ERR_EN=1:
  - CmdAck, then no src_rdy_n; Cmplt=Error=1 at T0+3; memory unchanged.
- Rd and Wr asserted together:
  - read serviced and write data ignored.
- Request dropped before ack:
  - no CmdAck, FSM returns to IDLE.
- Mst_Reset asserted in DATA:
  - no beat, no Cmplt; the next request is serviced normally.
- Address wrap with MEM_AW=10:
  - a write to 0x0000_1004 is read back from 0x0000_0004.
